mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters A_WIDTH (default 32; address width) and TIMEOUT (default 255; max wait cycles for m_ready per transaction, 1..65535).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_a  in  A_WIDTH  instruction-side address
- i_strobe  in  1  instruction-side request, read only
- i_din  out  32  instruction-side read data
- i_ready  out  1  instruction-side completion pulse
- d_a  in  A_WIDTH  data-side address
- d_dout  in  32  data-side write data
- d_wen  in  4  data-side byte enables
- d_size  in  2  data-side access size
- d_rw  in  1  data-side direction, 0 read, 1 write
- d_strobe  in  1  data-side request
- d_din  out  32  data-side read data
- d_ready  out  1  data-side completion pulse
- m_a  out  A_WIDTH  memory address
- m_din  out  32  memory write data
- m_wen  out  4  memory byte enables
- m_size  out  2  memory access size
- m_rw  out  1  memory direction
- m_strobe  out  1  memory request
- m_dout  in  32  memory read data
- m_ready  in  1  memory completion
- bus_err  out  1  sticky timeout flag

Function
REQ-003 SHALL implement FSM states IDLE, I_BUSY, D_BUSY.
REQ-004 In IDLE, SHALL grant as follows:
- one strobe high: grant that side.
- both high: grant the side not held in last_grant (round-robin).
- neither high: stay in IDLE.
REQ-005 On grant, SHALL register the winner's request attributes into m_a, m_din, m_wen, m_size, m_rw at the same clock edge, and SHALL set m_strobe=1 from the next cycle.
- I-side: m_rw=0, m_wen=4'b0000, m_size=2'b10, m_din=0.
REQ-006 While busy, m_* outputs SHALL stay stable regardless of requester inputs.
REQ-007 In x_BUSY with m_ready=1:
- x_ready SHALL be 1 in the same cycle (combinational).
- x_din SHALL equal m_dout in the same cycle.
- At the next edge: m_strobe SHALL go to 0, last_grant SHALL be set to x, state SHALL go to IDLE.
REQ-008 The non-owner's ready SHALL stay 0 at all times; x_din SHALL be 0 when x_ready=0.
REQ-009 Minimum transaction cost SHALL be 2 cycles (grant cycle plus one busy cycle with m_ready=1), with one IDLE cycle between back-to-back transactions.
REQ-010 A 16-bit wait counter SHALL clear on grant and increment each busy cycle without m_ready.
REQ-011 If the counter reaches TIMEOUT and m_ready=0:
- owner's ready SHALL pulse 1 with x_din=0.
- bus_err SHALL set and remain set until rst.
- state SHALL return to IDLE and m_strobe SHALL drop at the next edge.
- last_grant SHALL update as in REQ-007.
REQ-012 If m_ready and the timeout coincide, SHALL treat the cycle as a normal completion with data and SHALL NOT set bus_err.
REQ-013 m_ready asserted while in IDLE SHALL be ignored (no ready pulse, no state change).
REQ-014 A requester dropping its strobe mid-transaction SHALL NOT abort it; the transaction completes and the ready pulse is still issued.
REQ-015 A requester that still holds its strobe in the cycle after its ready pulse SHALL be treated as a new request.

Reset
REQ-016 On rst=1 at a clock edge, SHALL set:
- state=IDLE, last_grant=I (D-side wins the first tie).
- m_strobe=0, m_a=0, m_din=0, m_wen=0, m_size=0, m_rw=0.
- counter=0, bus_err=0.
REQ-017 Reset mid-transaction SHALL abandon the transaction without a ready pulse; i_ready and d_ready SHALL be 0 while rst=1.

Verification
REQ-018 Single I read: i_strobe=1, i_a=0x1FC00000, memory returns 0xDEADBEEF after 3 cycles -> m_strobe high for exactly 3 cycles, m_a=0x1FC00000, m_rw=0, one i_ready pulse with i_din=0xDEADBEEF.
REQ-019 Simultaneous requests after reset, both held -> D served first, then I, then D; strictly alternating grants, never two outstanding.
REQ-020 D byte write: d_a=0x00000104, d_wen=4'b0010, d_dout=0x0000AB00, d_rw=1, d_size=0 -> m_* equal those values while busy; d_ready=1 coincident with m_ready=1.
REQ-021 Timeout with TIMEOUT=4 and m_ready held 0 -> m_strobe drops after 4 busy cycles, owner ready pulses with data 0, bus_err=1 and stays 1 until rst.
REQ-022 rst asserted during D_BUSY -> next cycle m_strobe=0, no d_ready pulse; a following I request is granted normally.
REQ-023 Input change while busy (d_a altered mid-transaction) -> m_a unchanged until completion.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-requester memory arbiter. Arbitrates a read-only
//             instruction port (I) and a read/write data port (D) onto a
//             single memory request port. Ties alternate between the two
//             sides. A per-transaction wait counter aborts a transaction
//             that the memory never completes and raises a sticky bus_err.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_a/i_strobe    - instruction request (address, request)
//             i_din/i_ready   - instruction read data / completion pulse
//             d_a/d_dout/d_wen/d_size/d_rw/d_strobe
//                             - data request attributes and request
//             d_din/d_ready   - data read data / completion pulse
//             m_a/m_din/m_wen/m_size/m_rw/m_strobe
//                             - registered memory request
//             m_dout/m_ready  - memory read data / completion
//             bus_err         - sticky timeout flag, cleared only by rst
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int A_WIDTH = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [A_WIDTH-1:0] i_a,
   input  logic               i_strobe,
   output logic [31:0]        i_din,
   output logic               i_ready,
   input  logic [A_WIDTH-1:0] d_a,
   input  logic [31:0]        d_dout,
   input  logic [3:0]         d_wen,
   input  logic [1:0]         d_size,
   input  logic               d_rw,
   input  logic               d_strobe,
   output logic [31:0]        d_din,
   output logic               d_ready,
   output logic [A_WIDTH-1:0] m_a,
   output logic [31:0]        m_din,
   output logic [3:0]         m_wen,
   output logic [1:0]         m_size,
   output logic               m_rw,
   output logic               m_strobe,
   input  logic [31:0]        m_dout,
   input  logic               m_ready,
   output logic               bus_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } state_t;

   // The timeout fires in the busy cycle that would bring the wait count
   // up to TIMEOUT, so the memory gets exactly TIMEOUT busy cycles.
   localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic        last_grant_d;   // 1: D side won the previous grant
   logic [15:0] wait_cnt;

   logic        busy;
   logic        timeout_hit;
   logic        done;
   logic        grant_i;
   logic        grant_d;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next state, grant decision and requester-facing outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_next  = state;
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      i_ready     = 1'b0;
      i_din       = 32'h0;
      d_ready     = 1'b0;
      d_din       = 32'h0;

      busy        = (state != IDLE);
      // m_ready takes priority: a completion in the timeout cycle is normal.
      timeout_hit = busy && !m_ready && (wait_cnt == TIMEOUT_M1);
      done        = busy && (m_ready || timeout_hit);

      case (state)
         IDLE: begin
            if (i_strobe && d_strobe) begin
               grant_d = !last_grant_d;
               grant_i = last_grant_d;
            end else begin
               grant_i = i_strobe;
               grant_d = d_strobe;
            end
            if (grant_i) begin
               state_next = I_BUSY;
            end else if (grant_d) begin
               state_next = D_BUSY;
            end
         end
         I_BUSY: begin
            if (done) begin
               state_next = IDLE;
            end
            i_ready = done && !rst;
            // A timed-out completion returns zero data.
            i_din   = (i_ready && m_ready) ? m_dout : 32'h0;
         end
         D_BUSY: begin
            if (done) begin
               state_next = IDLE;
            end
            d_ready = done && !rst;
            d_din   = (d_ready && m_ready) ? m_dout : 32'h0;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registered memory request, wait counter, round-robin history, error
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         m_a          <= '0;
         m_din        <= 32'h0;
         m_wen        <= 4'h0;
         m_size       <= 2'b00;
         m_rw         <= 1'b0;
         m_strobe     <= 1'b0;
         wait_cnt     <= 16'h0;
         last_grant_d <= 1'b0;
         bus_err      <= 1'b0;
      end else if (grant_i) begin
         m_a      <= i_a;
         m_din    <= 32'h0;
         m_wen    <= 4'h0;
         m_size   <= 2'b10;
         m_rw     <= 1'b0;
         m_strobe <= 1'b1;
         wait_cnt <= 16'h0;
      end else if (grant_d) begin
         m_a      <= d_a;
         m_din    <= d_dout;
         m_wen    <= d_wen;
         m_size   <= d_size;
         m_rw     <= d_rw;
         m_strobe <= 1'b1;
         wait_cnt <= 16'h0;
      end else if (done) begin
         m_strobe     <= 1'b0;
         last_grant_d <= (state == D_BUSY);
         if (timeout_hit) begin
            bus_err <= 1'b1;
         end
      end else if (busy) begin
         // Busy and not done implies m_ready is low this cycle.
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter (TIMEOUT = 4).
//             Table of cycle vectors, directed multi-cycle sequences and a
//             randomized phase compared against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int TB_TIMEOUT = 4;

   logic        clk;
   logic        rst;
   logic [31:0] i_a;
   logic        i_strobe;
   logic [31:0] i_din;
   logic        i_ready;
   logic [31:0] d_a;
   logic [31:0] d_dout;
   logic [3:0]  d_wen;
   logic [1:0]  d_size;
   logic        d_rw;
   logic        d_strobe;
   logic [31:0] d_din;
   logic        d_ready;
   logic [31:0] m_a;
   logic [31:0] m_din;
   logic [3:0]  m_wen;
   logic [1:0]  m_size;
   logic        m_rw;
   logic        m_strobe;
   logic [31:0] m_dout;
   logic        m_ready;
   logic        bus_err;

   mem_arbiter #(.A_WIDTH(32), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .i_a(i_a), .i_strobe(i_strobe), .i_din(i_din), .i_ready(i_ready),
      .d_a(d_a), .d_dout(d_dout), .d_wen(d_wen), .d_size(d_size),
      .d_rw(d_rw), .d_strobe(d_strobe), .d_din(d_din), .d_ready(d_ready),
      .m_a(m_a), .m_din(m_din), .m_wen(m_wen), .m_size(m_size),
      .m_rw(m_rw), .m_strobe(m_strobe), .m_dout(m_dout),
      .m_ready(m_ready), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_a = 32'h0; i_strobe = 1'b0;
      d_a = 32'h0; d_dout = 32'h0; d_wen = 4'h0; d_size = 2'b00;
      d_rw = 1'b0; d_strobe = 1'b0;
      m_dout = 32'h0; m_ready = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Cycle vector table
   // ---------------------------------------------------------------------
   typedef struct {
      logic        rst;
      logic        is;
      logic        ds;
      logic        mr;
      logic [31:0] mdout;
      logic        ms;
      logic [31:0] ma;
      logic        mrw;
      logic [3:0]  mwen;
      logic        ir;
      logic [31:0] idin;
      logic        dr;
      logic [31:0] ddin;
   } vec_t;

   vec_t tbl[13];

   // Transaction-level reference model state
   int          mo_owner;   // 0 none, 1 I, 2 D
   int          mo_age;     // busy cycles already spent in this transaction
   int          mo_last;    // side granted last: 1 I, 2 D
   bit          mo_err;
   logic [31:0] mo_a, mo_din;
   logic [3:0]  mo_wen;
   logic [1:0]  mo_size;
   logic        mo_rw;
   bit          e_busy, e_to, e_fin, e_ir, e_dr;
   logic [31:0] e_idin, e_ddin;
   int          winner;

   int          cnt_ms, cnt_rdy;
   logic [31:0] got_din;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // rst, is, ds, mr, mdout | ms, ma, mrw, mwen | ir, idin | dr, ddin
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,1'b0,4'h0,        1'b0,32'h0,        1'b0,32'h0};
      tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,1'b0,4'h0,        1'b0,32'h0,        1'b0,32'h0};
      tbl[2]  = '{1'b0,1'b1,1'b1,1'b1,32'h11111111, 1'b1,32'h104,1'b1,4'h2,      1'b0,32'h0,        1'b1,32'h11111111};
      tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h104,1'b1,4'h2,      1'b0,32'h0,        1'b0,32'h0};
      tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'h1FC00000,1'b0,4'h0, 1'b0,32'h0,        1'b0,32'h0};
      tbl[5]  = '{1'b0,1'b1,1'b1,1'b1,32'h22222222, 1'b1,32'h1FC00000,1'b0,4'h0, 1'b1,32'h22222222, 1'b0,32'h0};
      tbl[6]  = '{1'b0,1'b1,1'b1,1'b1,32'h99999999, 1'b0,32'h1FC00000,1'b0,4'h0, 1'b0,32'h0,        1'b0,32'h0};
      tbl[7]  = '{1'b0,1'b1,1'b1,1'b1,32'h33333333, 1'b1,32'h104,1'b1,4'h2,      1'b0,32'h0,        1'b1,32'h33333333};
      tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,32'h44444444, 1'b0,32'h104,1'b1,4'h2,      1'b0,32'h0,        1'b0,32'h0};
      tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h104,1'b1,4'h2,      1'b0,32'h0,        1'b0,32'h0};
      tbl[10] = '{1'b0,1'b1,1'b1,1'b1,32'h55555555, 1'b1,32'h1FC00000,1'b0,4'h0, 1'b1,32'h55555555, 1'b0,32'h0};
      tbl[11] = '{1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h1FC00000,1'b0,4'h0, 1'b0,32'h0,        1'b0,32'h0};
      tbl[12] = '{1'b0,1'b1,1'b1,1'b1,32'h66666666, 1'b1,32'h104,1'b1,4'h2,      1'b0,32'h0,        1'b1,32'h66666666};

      rst = 1'b1;
      clear_inputs();

      // ---------------- Table: arbitration, alternation, idle m_ready ----
      do_reset();
      i_a = 32'h1FC00000;
      d_a = 32'h104; d_dout = 32'hAB00; d_wen = 4'h2; d_size = 2'b00; d_rw = 1'b1;
      for (int r = 0; r < 13; r++) begin
         rst = tbl[r].rst; i_strobe = tbl[r].is; d_strobe = tbl[r].ds;
         m_ready = tbl[r].mr; m_dout = tbl[r].mdout;
         @(negedge clk);
         chk($sformatf("tbl%0d_m", r), {m_strobe, m_a, m_rw, m_wen},
             {tbl[r].ms, tbl[r].ma, tbl[r].mrw, tbl[r].mwen});
         chk($sformatf("tbl%0d_i", r), {i_ready, i_din}, {tbl[r].ir, tbl[r].idin});
         chk($sformatf("tbl%0d_d", r), {d_ready, d_din}, {tbl[r].dr, tbl[r].ddin});
         next_cycle();
      end

      // ---------------- Single I read, memory answers on 3rd busy cycle ---
      do_reset();
      i_a = 32'h1FC00000; i_strobe = 1'b1;
      @(negedge clk);
      chk("ird_grant_ms", m_strobe, 1'b0);
      next_cycle();
      i_strobe = 1'b0;   // dropping the strobe must not abort the read
      cnt_ms = 0; cnt_rdy = 0; got_din = 32'h0;
      for (int k = 0; k < 8; k++) begin
         m_ready = (k == 2);
         m_dout  = (k == 2) ? 32'hDEADBEEF : 32'h0;
         @(negedge clk);
         if (k == 0) chk("ird_attr", {m_a, m_rw, m_wen, m_size, m_din},
                         {32'h1FC00000, 1'b0, 4'h0, 2'b10, 32'h0});
         if (m_strobe) cnt_ms++;
         if (i_ready) begin cnt_rdy++; got_din = i_din; end
         if (d_ready) cnt_rdy += 100;
         next_cycle();
      end
      m_ready = 1'b0;
      chk("ird_strobe_cycles", cnt_ms, 3);
      chk("ird_ready_pulses", cnt_rdy, 1);
      chk("ird_data", got_din, 32'hDEADBEEF);

      // ---------------- D byte write, address changed mid-transaction ----
      do_reset();
      d_a = 32'h104; d_wen = 4'b0010; d_dout = 32'h0000AB00; d_rw = 1'b1;
      d_size = 2'b00; d_strobe = 1'b1;
      next_cycle();
      d_strobe = 1'b0; d_a = 32'hFFFF0000; d_dout = 32'h12345678; d_wen = 4'hF;
      d_size = 2'b11; d_rw = 1'b0;
      @(negedge clk);
      chk("dwr_attr", {m_strobe, m_a, m_din, m_wen, m_size, m_rw},
          {1'b1, 32'h104, 32'h0000AB00, 4'b0010, 2'b00, 1'b1});
      chk("dwr_wait_ready", {d_ready, i_ready}, 2'b00);
      next_cycle();
      m_ready = 1'b1; m_dout = 32'hCAFEF00D;
      @(negedge clk);
      chk("dwr_done", {d_ready, d_din, i_ready, m_a}, {1'b1, 32'hCAFEF00D, 1'b0, 32'h104});
      next_cycle();
      m_ready = 1'b0;
      @(negedge clk);
      chk("dwr_after", {m_strobe, d_ready}, 2'b00);
      next_cycle();

      // ---------------- m_ready coinciding with the timeout cycle --------
      do_reset();
      d_strobe = 1'b1; d_a = 32'h200;
      next_cycle();
      d_strobe = 1'b0;
      for (int k = 0; k < TB_TIMEOUT; k++) begin
         m_ready = (k == TB_TIMEOUT - 1);
         m_dout  = 32'h5A5A5A5A;
         @(negedge clk);
         if (k == TB_TIMEOUT - 1)
            chk("coin_done", {m_strobe, d_ready, d_din}, {1'b1, 1'b1, 32'h5A5A5A5A});
         next_cycle();
      end
      m_ready = 1'b0;
      @(negedge clk);
      chk("coin_no_err", {m_strobe, bus_err}, 2'b00);
      next_cycle();

      // ---------------- Timeout with memory silent -----------------------
      do_reset();
      i_a = 32'h300; i_strobe = 1'b1;
      next_cycle();
      i_strobe = 1'b0; m_dout = 32'hFFFFFFFF;
      cnt_rdy = 0;
      for (int k = 0; k < TB_TIMEOUT; k++) begin
         @(negedge clk);
         if (k < TB_TIMEOUT - 1) begin
            if (i_ready || !m_strobe) cnt_rdy++;
         end else begin
            chk("to_pulse", {m_strobe, i_ready, i_din, bus_err, d_ready},
                {1'b1, 1'b1, 32'h0, 1'b0, 1'b0});
         end
         next_cycle();
      end
      chk("to_no_early", cnt_rdy, 0);
      @(negedge clk);
      chk("to_after", {m_strobe, bus_err, i_ready}, 3'b010);
      next_cycle();
      d_strobe = 1'b1; m_ready = 1'b1; m_dout = 32'h77;
      next_cycle();
      next_cycle();
      d_strobe = 1'b0; m_ready = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("to_sticky", bus_err, 1'b1);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("to_rst_clears", bus_err, 1'b0);
      next_cycle();

      // ---------------- Reset during D_BUSY ------------------------------
      do_reset();
      d_strobe = 1'b1; d_a = 32'h400;
      next_cycle();
      d_strobe = 1'b0;
      @(negedge clk);
      chk("rstd_busy", m_strobe, 1'b1);
      next_cycle();
      rst = 1'b1; m_ready = 1'b1; m_dout = 32'h1234;
      @(negedge clk);
      chk("rstd_no_ready", {d_ready, i_ready}, 2'b00);
      next_cycle();
      rst = 1'b0; m_ready = 1'b0; i_strobe = 1'b1; i_a = 32'h500;
      @(negedge clk);
      chk("rstd_idle", {m_strobe, d_ready}, 2'b00);
      next_cycle();
      i_strobe = 1'b0; m_ready = 1'b1; m_dout = 32'h0BADF00D;
      @(negedge clk);
      chk("rstd_i_ok", {i_ready, i_din, m_a}, {1'b1, 32'h0BADF00D, 32'h500});
      next_cycle();
      m_ready = 1'b0;

      // ---------------- Randomized phase against the model ---------------
      for (int n = 0; n < 3000; n++) begin
         rst      = (n == 0) || ($urandom_range(0, 99) == 0);
         i_strobe = ($urandom_range(0, 2) != 0);
         d_strobe = ($urandom_range(0, 2) != 0);
         i_a      = $urandom;
         d_a      = $urandom;
         d_dout   = $urandom;
         d_wen    = 4'($urandom);
         d_size   = 2'($urandom);
         d_rw     = 1'($urandom);
         m_ready  = ($urandom_range(0, 3) == 0);
         m_dout   = $urandom;
         @(negedge clk);
         e_busy = (mo_owner != 0);
         e_to   = e_busy && !m_ready && (mo_age + 1 == TB_TIMEOUT);
         e_fin  = e_busy && (m_ready || e_to);
         e_ir   = !rst && e_fin && (mo_owner == 1);
         e_dr   = !rst && e_fin && (mo_owner == 2);
         e_idin = (e_ir && m_ready) ? m_dout : 32'h0;
         e_ddin = (e_dr && m_ready) ? m_dout : 32'h0;
         if (n > 0) begin
            chk($sformatf("rnd%0d_m", n), {m_strobe, m_a, m_din, m_wen, m_size, m_rw},
                {e_busy, mo_a, mo_din, mo_wen, mo_size, mo_rw});
            chk($sformatf("rnd%0d_rdy", n), {i_ready, i_din, d_ready, d_din, bus_err},
                {e_ir, e_idin, e_dr, e_ddin, mo_err});
         end
         if (rst) begin
            mo_owner = 0; mo_age = 0; mo_last = 1; mo_err = 1'b0;
            mo_a = 32'h0; mo_din = 32'h0; mo_wen = 4'h0; mo_size = 2'b00; mo_rw = 1'b0;
         end else if (mo_owner == 0) begin
            if (i_strobe && d_strobe) winner = (mo_last == 1) ? 2 : 1;
            else if (i_strobe)        winner = 1;
            else if (d_strobe)        winner = 2;
            else                      winner = 0;
            if (winner == 1) begin
               mo_a = i_a; mo_din = 32'h0; mo_wen = 4'h0; mo_size = 2'b10; mo_rw = 1'b0;
            end else if (winner == 2) begin
               mo_a = d_a; mo_din = d_dout; mo_wen = d_wen; mo_size = d_size; mo_rw = d_rw;
            end
            mo_owner = winner;
            mo_age   = 0;
         end else if (e_fin) begin
            mo_last  = mo_owner;
            mo_owner = 0;
            if (e_to) mo_err = 1'b1;
         end else begin
            mo_age++;
         end
         next_cycle();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
